// File: rtl/bram_wr_delay_line_pkg.sv
// -----------------------------------------------------------------------------
// bram_wr_delay_line_pkg
//   Shared defaults and types for the BRAM write-control delay line.
//   - *_DEF localparams : default parameter values for the top module.
//   - wr_entry_t        : one pending write {we, addr, data} at default widths.
//   - lat_in_range()    : legality check for a requested latency.
// -----------------------------------------------------------------------------
package bram_wr_delay_line_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int MAX_DEPTH_DEF  = 8;
    localparam int DEF_LAT_DEF    = 4;

    typedef struct packed {
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wr_entry_t;

    // A latency selects which physical stage drives the outputs, so it must
    // name an existing stage: 1..max_depth.
    function automatic bit lat_in_range(input int lat, input int max_depth);
        return (lat >= 1) && (lat <= max_depth);
    endfunction

endpackage

// File: rtl/bram_wr_stage.sv
// -----------------------------------------------------------------------------
// bram_wr_stage
//   One register of the write delay line, with hold and clear controls.
//   Clear wins over hold, so a flush always empties the line even while it
//   is stalled.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     i_hold  : keep the current contents (stall)
//     i_clr   : load zero (flush), priority over i_hold
//     i_d     : next entry from the previous stage / line input
//     o_q     : registered entry
// -----------------------------------------------------------------------------
module bram_wr_stage #(
    parameter int W = 22
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_hold,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would collapse
    // the line into a single register.
    // NOTE: the line is built from flops rather than a RAM, so every entry is
    // reset; the outputs and hazard flag are then well defined after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bram_wr_delay_line.sv
// -----------------------------------------------------------------------------
// bram_wr_delay_line
//   Delays BRAM write-enable/address/data by a runtime-programmable number of
//   cycles so the write lines up with the DSP pipeline depth.
//   Ports:
//     clk_i, rst_ni            : clock, async active-low reset
//     we_i, w_addr_i, w_data_i : write from the compute datapath
//     stall_i                  : hold every stage, drop the current input
//     flush_i                  : kill every in-flight write (beats stall_i)
//     lat_load_i, lat_i        : request a new latency (1..MAX_DEPTH)
//     rd_addr_i                : read address checked against pending writes
//     we_o, w_addr_o, w_data_o : delayed write toward the BRAM port
//     lat_o                    : current latency
//     lat_err_o                : one-cycle pulse on a rejected latency load
//     inflight_o               : pending writes within the active stages
//     hazard_o                 : rd_addr_i matches a pending write
// -----------------------------------------------------------------------------
module bram_wr_delay_line
    import bram_wr_delay_line_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_DEPTH  = MAX_DEPTH_DEF,
    parameter int DEF_LAT    = DEF_LAT_DEF,
    parameter int LAT_W      = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] w_addr_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  lat_load_i,
    input  logic [LAT_W-1:0]      lat_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [LAT_W-1:0]      lat_o,
    output logic                  lat_err_o,
    output logic [LAT_W-1:0]      inflight_o,
    output logic                  hazard_o
);

    // Stage record at this instance's widths.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    stage_t           w_stage_in;
    stage_t           w_stage_q [MAX_DEPTH];
    stage_t           w_out;
    logic [LAT_W-1:0] w_inflight;
    logic             w_hazard;
    logic             w_lat_ok;

    logic [LAT_W-1:0] r_lat_q;
    logic             r_lat_err;

    assign w_stage_in = '{we: we_i, addr: w_addr_i, data: w_data_i};

    // ---------------------------------------------------------------- stages
    // Every physical stage always shifts; the latency only decides which one
    // is observed, so changing it never needs to move data around.
    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
        stage_t w_d;

        if (k == 0) begin : g_head
            assign w_d = w_stage_in;
        end else begin : g_tail
            assign w_d = w_stage_q[k-1];
        end

        bram_wr_stage #(
            .W (STAGE_W)
        ) u_stage (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_hold  (stall_i),
            .i_clr   (flush_i),
            .i_d     (w_d),
            .o_q     (w_stage_q[k])
        );
    end

    // ------------------------------------------- output mux, count, hazard
    // NOTE: every variable is given a default before the loop so no path
    // leaves it unassigned; otherwise synthesis would infer latches.
    always_comb begin
        w_out      = '0;
        w_inflight = '0;
        w_hazard   = 1'b0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            // Only stages below the current latency are real pending writes;
            // deeper stages hold stale entries that are still shifting out.
            if (k < int'(r_lat_q) && w_stage_q[k].we) begin
                w_inflight = w_inflight + LAT_W'(1);
                if (w_stage_q[k].addr == rd_addr_i) begin
                    w_hazard = 1'b1;
                end
            end
            if (k == int'(r_lat_q) - 1) begin
                w_out = w_stage_q[k];
            end
        end
    end

    // ------------------------------------------------------------- latency
    // A load is only safe on an empty, moving line: otherwise writes already
    // in flight would be delivered early, late or twice. With a flush in the
    // same cycle the pre-flush count still decides.
    assign w_lat_ok = lat_load_i
                   && (w_inflight == '0)
                   && !stall_i
                   && lat_in_range(int'(lat_i), MAX_DEPTH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lat_q   <= LAT_W'(DEF_LAT);
            r_lat_err <= 1'b0;
        end else begin
            if (w_lat_ok) begin
                r_lat_q <= lat_i;
            end
            r_lat_err <= lat_load_i && !w_lat_ok;
        end
    end

    // ------------------------------------------------------------- outputs
    assign we_o       = w_out.we;
    assign w_addr_o   = w_out.addr;
    assign w_data_o   = w_out.data;
    assign lat_o      = r_lat_q;
    assign lat_err_o  = r_lat_err;
    assign inflight_o = w_inflight;
    assign hazard_o   = w_hazard;

endmodule

// File: tb/tb_bram_wr_delay_line.sv
// -----------------------------------------------------------------------------
// tb_bram_wr_delay_line
//   Scoreboard bench: each tracked write is queued with the cycle on which it
//   must reach the outputs; a negedge monitor pops and compares deliveries.
//   Scenario tasks add inline checks on count, hazard and latency behaviour.
// -----------------------------------------------------------------------------
module tb_bram_wr_delay_line;
    import bram_wr_delay_line_pkg::*;

    localparam int AW = ADDR_WIDTH_DEF;
    localparam int DW = DATA_WIDTH_DEF;
    localparam int MD = MAX_DEPTH_DEF;
    localparam int DL = DEF_LAT_DEF;
    localparam int LW = $clog2(MD + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          we_i;
    logic [AW-1:0] w_addr_i;
    logic [DW-1:0] w_data_i;
    logic          stall_i;
    logic          flush_i;
    logic          lat_load_i;
    logic [LW-1:0] lat_i;
    logic [AW-1:0] rd_addr_i;
    logic          we_o;
    logic [AW-1:0] w_addr_o;
    logic [DW-1:0] w_data_o;
    logic [LW-1:0] lat_o;
    logic          lat_err_o;
    logic [LW-1:0] inflight_o;
    logic          hazard_o;

    bram_wr_delay_line dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (we_i),
        .w_addr_i   (w_addr_i),
        .w_data_i   (w_data_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .lat_load_i (lat_load_i),
        .lat_i      (lat_i),
        .rd_addr_i  (rd_addr_i),
        .we_o       (we_o),
        .w_addr_o   (w_addr_o),
        .w_data_o   (w_data_o),
        .lat_o      (lat_o),
        .lat_err_o  (lat_err_o),
        .inflight_o (inflight_o),
        .hazard_o   (hazard_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        wr_entry_t e;
        int        due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   cur_lat  = DL;
    logic r_stall_seen = 1'b0;

    // cyc = number of rising edges so far; r_stall_seen marks a held edge,
    // after which the outputs repeat and must not count as a new delivery.
    always @(posedge clk_i) begin
        cyc          <= cyc + 1;
        r_stall_seen <= stall_i;
    end

    // ------------------------------------------------------------- monitor
    always @(negedge clk_i) begin : monitor
        exp_t x;
        if (rst_ni === 1'b1 && we_o === 1'b1 && !r_stall_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL deliver: unexpected write addr=%h data=%h at cycle %0d, required none",
                         w_addr_o, w_data_o, cyc);
            end else begin
                x = exp_q.pop_front();
                if (w_addr_o !== x.e.addr || w_data_o !== x.e.data || cyc != x.due) begin
                    failures++;
                    $display("FAIL deliver: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                             w_addr_o, w_data_o, cyc, x.e.addr, x.e.data, x.due);
                end
            end
        end
    end

    // ---------------------------------------------------- stimulus helpers
    // Called at a negedge; drives one write for one edge. Tracked writes are
    // expected after cur_lat-1 further edges plus any stalled edges.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit track, input int extra);
        exp_t x;
        we_i     = 1'b1;
        w_addr_i = a;
        w_data_i = d;
        if (track) begin
            x.e.we   = 1'b1;
            x.e.addr = a;
            x.e.data = d;
            x.due    = cyc + cur_lat + extra;
            exp_q.push_back(x);
        end
        @(negedge clk_i);
        we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        we_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic load_lat(input logic [LW-1:0] l);
        lat_load_i = 1'b1;
        lat_i      = l;
        @(negedge clk_i);
        lat_load_i = 1'b0;
    endtask

    // Waits (bounded) for the scoreboard to empty; callers check the result.
    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] obs [7];
        logic [31:0] req [7];
        rst_ni = 1'b0; we_i = 1'b0; w_addr_i = '0; w_data_i = '0;
        stall_i = 1'b0; flush_i = 1'b0; lat_load_i = 1'b0; lat_i = '0; rd_addr_i = '0;
        repeat (2) @(negedge clk_i);
        obs = '{32'(we_o), 32'(w_addr_o), 32'(w_data_o), 32'(lat_o),
                32'(lat_err_o), 32'(inflight_o), 32'(hazard_o)};
        req = '{0, 0, 0, DL, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== req[i]) begin
                failures++;
                $display("FAIL reset[%0d]: got %0h, required %0h", i, obs[i], req[i]);
            end
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        int c0;
        c0 = cyc;
        send(5'h0A, 16'h1234, 1'b1, 0);
        // Visible only on the cycle DL-1 edges after the sampling edge.
        for (int i = 0; i < DL + 1; i++) begin
            checks++;
            if (we_o !== (cyc == c0 + DL)) begin
                failures++;
                $display("FAIL basic_we: cycle %0d got we_o=%b, required %b", cyc, we_o, cyc == c0 + DL);
            end
            @(negedge clk_i);
        end
        send(5'h03, 16'hAAAA, 1'b1, 0);
        send(5'h03, 16'hBBBB, 1'b1, 0);
        for (int i = 0; i < 4; i++) send(AW'($urandom), DW'($urandom), 1'b1, 0);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_drain: %0d writes undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        send(5'h07, 16'hBEEF, 1'b1, 3);
        stall_i  = 1'b1;
        we_i     = 1'b1;
        w_addr_i = 5'h1F;
        w_data_i = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (inflight_o !== LW'(1)) begin
                failures++;
                $display("FAIL stall_inflight: got %0d, required 1", inflight_o);
            end
        end
        stall_i = 1'b0;
        we_i    = 1'b0;
        drain();
        idle(MD);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain: %0d writes undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        send(5'h01, 16'h1111, 1'b0, 0);
        send(5'h02, 16'h2222, 1'b0, 0);
        send(5'h03, 16'h3333, 1'b0, 0);
        checks++;
        if (inflight_o !== LW'(3)) begin
            failures++;
            $display("FAIL flush_pre: inflight got %0d, required 3", inflight_o);
        end
        flush_i  = 1'b1;
        we_i     = 1'b1;
        w_addr_i = 5'h04;
        w_data_i = 16'h4444;
        @(negedge clk_i);
        flush_i = 1'b0;
        we_i    = 1'b0;
        checks++;
        if (inflight_o !== '0 || we_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_post: inflight=%0d we_o=%b, required 0 0", inflight_o, we_o);
        end
        idle(MD + 2);   // any late delivery is flagged by the monitor
    endtask

    task automatic test_latency();
        load_lat(LW'(2));
        checks++;
        if (lat_o !== LW'(2) || lat_err_o !== 1'b0) begin
            failures++;
            $display("FAIL lat_load2: lat_o=%0d err=%b, required 2 0", lat_o, lat_err_o);
        end
        cur_lat = 2;
        send(5'h05, 16'h5555, 1'b1, 0);
        drain();
        for (int i = 0; i < 2; i++) begin
            load_lat(i == 0 ? LW'(0) : LW'(9));
            checks++;
            if (lat_err_o !== 1'b1 || lat_o !== LW'(2)) begin
                failures++;
                $display("FAIL lat_range%0d: err=%b lat_o=%0d, required 1 2", i, lat_err_o, lat_o);
            end
            @(negedge clk_i);
            checks++;
            if (lat_err_o !== 1'b0) begin
                failures++;
                $display("FAIL lat_pulse%0d: err=%b, required 0", i, lat_err_o);
            end
        end
        send(5'h06, 16'h6666, 1'b1, 0);
        load_lat(LW'(3));   // one write still in the active stages
        checks++;
        if (lat_err_o !== 1'b1 || lat_o !== LW'(2)) begin
            failures++;
            $display("FAIL lat_busy: err=%b lat_o=%0d, required 1 2", lat_err_o, lat_o);
        end
        idle(MD);
        stall_i = 1'b1;
        load_lat(LW'(3));
        stall_i = 1'b0;
        checks++;
        if (lat_err_o !== 1'b1 || lat_o !== LW'(2)) begin
            failures++;
            $display("FAIL lat_stall: err=%b lat_o=%0d, required 1 2", lat_err_o, lat_o);
        end
        // Boundaries: deepest and shallowest legal latency.
        load_lat(LW'(MD));
        cur_lat = MD;
        send(5'h08, 16'h8888, 1'b1, 0);
        drain();
        load_lat(LW'(1));
        cur_lat = 1;
        send(5'h09, 16'h9999, 1'b1, 0);
        send(5'h09, 16'h9A9A, 1'b1, 0);
        drain();
        idle(MD);   // let stale entries shift out before growing the latency
        load_lat(LW'(DL));
        cur_lat = DL;
        checks++;
        if (lat_o !== LW'(DL) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL lat_restore: lat_o=%0d pending=%0d, required %0d 0", lat_o, exp_q.size(), DL);
        end
    endtask

    task automatic test_hazard();
        rd_addr_i = 5'h11;
        we_i      = 1'b1;
        w_addr_i  = 5'h11;
        #1;
        checks++;
        if (hazard_o !== 1'b0) begin
            failures++;
            $display("FAIL hazard_input: got %b, required 0", hazard_o);
        end
        send(5'h11, 16'hC0DE, 1'b1, 0);
        for (int i = 0; i < DL + 1; i++) begin
            #1;
            checks++;
            if (hazard_o !== (i < DL)) begin
                failures++;
                $display("FAIL hazard_stage%0d: got %b, required %b", i, hazard_o, i < DL);
            end
            if (i == 1) begin
                rd_addr_i = 5'h12;
                #1;
                checks++;
                if (hazard_o !== 1'b0) begin
                    failures++;
                    $display("FAIL hazard_other: got %b, required 0", hazard_o);
                end
                rd_addr_i = 5'h11;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] obs [7];
        logic [31:0] req [7];
        idle(MD);
        load_lat(LW'(2));
        cur_lat   = 2;
        rd_addr_i = 5'h15;
        send(5'h14, 16'hA1A1, 1'b1, 0);
        send(5'h15, 16'hB2B2, 1'b1, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        obs = '{32'(we_o), 32'(w_addr_o), 32'(w_data_o), 32'(lat_o),
                32'(lat_err_o), 32'(inflight_o), 32'(hazard_o)};
        req = '{0, 0, 0, DL, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs[i] !== req[i]) begin
                failures++;
                $display("FAIL async_reset[%0d]: got %0h, required %0h", i, obs[i], req[i]);
            end
        end
        exp_q.delete();
        cur_lat = DL;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(MD);
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_latency();
        test_hazard();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
